// File: rtl/ram_peri_pkg.sv
// ram_peri_pkg: shared types and constants for the ram_peri_dp memory peripheral
package ram_peri_pkg;
  typedef enum logic {INIT, RUN} state_e;
  localparam int CFillSeed = 1;
  // Galois right-shift tap masks, one entry per supported width
  function automatic logic [31:0] lfsr_taps(input int w);
    case (w)
      2:       return 32'h0000_0003;
      3:       return 32'h0000_0006;
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      16:      return 32'h0000_B400;
      32:      return 32'hA300_0000;
      default: return 32'h0000_00B8;
    endcase
  endfunction
endpackage

// File: rtl/ram_peri_dp_rd_pipe.sv
// ram_peri_dp_rd_pipe: CLat-stage read data/valid shift with clock enable and reset flush
// Ports: clk, rst (sync, high), en (clock enable), vld_in/data_in (stage input),
//        vld_out/data_out (last stage; data holds while no valid arrives)
module ram_peri_rd_pipe #(
  parameter int CDataLen = 8,
  parameter int CLat = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                vld_in,
  input  logic [CDataLen-1:0] data_in,
  output logic                vld_out,
  output logic [CDataLen-1:0] data_out
);
  logic [CLat-1:0]               vld_q, vld_d;
  logic [CLat-1:0][CDataLen-1:0] data_q, data_d;
  always_comb begin
    vld_d = vld_q;
    data_d = data_q;
    if (en) begin
      vld_d[0] = vld_in;
      data_d[0] = vld_in ? data_in : data_q[0];
      for (int k = 1; k < CLat; k++) begin
        vld_d[k] = vld_q[k-1];
        data_d[k] = vld_q[k-1] ? data_q[k-1] : data_q[k];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      data_q <= '0;
    end else begin
      vld_q <= vld_d;
      data_q <= data_d;
    end
  end
  assign vld_out = vld_q[CLat-1];
  assign data_out = data_q[CLat-1];
endmodule

// File: rtl/ram_peri_dp.sv
// ram_peri_dp: simple dual-port RAM peripheral with self-initialisation and collision policy
// Ports: AClkH/AResetH (clock, sync active-high reset), AClkHEn (clock enable),
//        AAddrWr/AMosi/AWrEn (write port), AAddrRd/ARdEn (read port),
//        AMiso/AMisoVld (read data + valid pulse), ABusy (initialisation running).
// Optional: define RAM_PERI_LFSR_FILL_EN to fill with a Galois LFSR pattern instead of zero.
module ram_peri_dp
  import ram_peri_pkg::*;
#(
  parameter int CAddrLen = 8,
  parameter int CDataLen = 8,
  parameter int CDepth = 256,
  parameter int CRdLat = 1,
  parameter int CWrFirst = 1
) (
  input  logic                AClkH,
  input  logic                AResetH,
  input  logic                AClkHEn,
  input  logic [CAddrLen-1:0] AAddrWr,
  input  logic [CDataLen-1:0] AMosi,
  input  logic                AWrEn,
  input  logic [CAddrLen-1:0] AAddrRd,
  input  logic                ARdEn,
  output logic [CDataLen-1:0] AMiso,
  output logic                AMisoVld,
  output logic                ABusy
);
  // one extra bit so a full 2**CAddrLen depth compares without wrapping
  localparam logic [CAddrLen:0] CDepthW = (CAddrLen+1)'(CDepth);
  localparam logic [CAddrLen:0] CLast = (CAddrLen+1)'(CDepth - 1);
  state_e                state_q, state_d;
  logic [CAddrLen:0]     cnt_q, cnt_d;
  logic [CDataLen-1:0]   mem_q [CDepth];
  logic [CDataLen-1:0]   fill, rd_data, wr_data;
  logic [CAddrLen-1:0]   wr_idx;
  logic                  run, wr_hit, rd_hit, coll, wr_en, rd_vld;
`ifdef RAM_PERI_LFSR_FILL_EN
  localparam logic [CDataLen-1:0] CTaps = CDataLen'(lfsr_taps(CDataLen));
  logic [CDataLen-1:0] lfsr_q, lfsr_d;
  always_comb lfsr_d = (AClkHEn && !run) ? ((lfsr_q >> 1) ^ (lfsr_q[0] ? CTaps : '0)) : lfsr_q;
  always_ff @(posedge AClkH) lfsr_q <= AResetH ? CDataLen'(CFillSeed) : lfsr_d;
  assign fill = lfsr_q;
`else
  assign fill = '0;
`endif
  assign run = state_q == RUN;
  assign ABusy = !run;
  assign wr_hit = {1'b0, AAddrWr} < CDepthW;
  assign rd_hit = {1'b0, AAddrRd} < CDepthW;
  assign coll = AWrEn && wr_hit && AAddrWr == AAddrRd;
  // write-first bypasses the array; read-first sees the pre-edge contents
  assign rd_data = !rd_hit ? '0 : (coll && CWrFirst != 0) ? AMosi : mem_q[AAddrRd];
  assign rd_vld = run && ARdEn;
  assign wr_en = !AResetH && AClkHEn && (run ? AWrEn && wr_hit : 1'b1);
  assign wr_idx = run ? AAddrWr : cnt_q[CAddrLen-1:0];
  assign wr_data = run ? AMosi : fill;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (AClkHEn && !run) begin
      cnt_d = cnt_q + 1'b1;
      state_d = cnt_q == CLast ? RUN : INIT;
    end
  end
  always_ff @(posedge AClkH) begin
    if (AResetH) begin
      state_q <= INIT;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge AClkH) if (wr_en) mem_q[wr_idx] <= wr_data;
  ram_peri_rd_pipe #(.CDataLen(CDataLen), .CLat(CRdLat)) u_rd_pipe (
    .clk     (AClkH),
    .rst     (AResetH),
    .en      (AClkHEn),
    .vld_in  (rd_vld),
    .data_in (rd_data),
    .vld_out (AMisoVld),
    .data_out(AMiso)
  );
endmodule

// File: tb/tb_ram_peri_dp.sv
// tb_ram_peri_dp: directed self-checking bench for ram_peri_dp
module tb_ram_peri_dp;
  localparam int DEPTH = 200;
  localparam int LAT = 2;
  localparam int WRF = 1;
  logic       clk = 0;
  logic       rst, en, wr_en, rd_en, vld, busy;
  logic [7:0] addr_wr, addr_rd, mosi, miso;
  int checks = 0;
  int errors = 0;
  ram_peri_dp #(.CAddrLen(8), .CDataLen(8), .CDepth(DEPTH), .CRdLat(LAT), .CWrFirst(WRF)) dut (
    .AClkH(clk), .AResetH(rst), .AClkHEn(en), .AAddrWr(addr_wr), .AMosi(mosi), .AWrEn(wr_en),
    .AAddrRd(addr_rd), .ARdEn(rd_en), .AMiso(miso), .AMisoVld(vld), .ABusy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] fill(input int n);
    logic [7:0] s = 8'h00;
`ifdef RAM_PERI_LFSR_FILL_EN
    s = 8'h01;
    repeat (n) s = s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
`endif
    return s;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    addr_wr = a; mosi = d; wr_en = 1; tick(); wr_en = 0;
  endtask
  // issues one read; ok is cleared if the valid pulse is not exactly LAT cycles later and one wide
  task automatic rd(input logic [7:0] a, output logic [7:0] d, output bit ok);
    addr_rd = a; rd_en = 1; ok = 1; tick(); rd_en = 0;
    for (int i = 1; i < LAT; i++) begin
      if (vld) ok = 0;
      tick();
    end
    if (vld !== 1'b1) ok = 0;
    d = miso;
    tick();
    if (vld !== 1'b0) ok = 0;
  endtask
  task automatic count_init(input string name);
    int n = 0;
    int seen = 0;
    while (busy && n < 1000) begin
      tick(); n++;
      if (vld) seen++;
    end
    checks++; if (n != DEPTH) begin errors++; $display("FAIL %s busy cycles: got %0d want %0d", name, n, DEPTH); end
    checks++; if (seen != 0) begin errors++; $display("FAIL %s vld during init: got %0d want 0", name, seen); end
  endtask
  task automatic test_reset();
    logic [7:0] d; bit ok;
    rst = 1; en = 0; tick(); tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset busy: got %b want 1", busy); end
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL reset vld: got %b want 0", vld); end
    checks++; if (miso !== 8'h00) begin errors++; $display("FAIL reset miso: got %h want 00", miso); end
    en = 1; tick(); rst = 0;
    addr_wr = 8'h05; mosi = 8'h77; wr_en = 1; addr_rd = 8'h05; rd_en = 1;
    count_init("init");
    wr_en = 0; rd_en = 0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL init done busy: got %b want 0", busy); end
    rd(8'h05, d, ok);
    checks++; if (!ok || d !== fill(5)) begin errors++; $display("FAIL init write dropped: got %h ok=%0d want %h", d, ok, fill(5)); end
    rd(8'h37, d, ok);
    checks++; if (!ok || d !== fill(8'h37)) begin errors++; $display("FAIL init fill 37: got %h ok=%0d want %h", d, ok, fill(8'h37)); end
    rd(8'h00, d, ok);
    checks++; if (!ok || d !== fill(0)) begin errors++; $display("FAIL init fill 00: got %h ok=%0d want %h", d, ok, fill(0)); end
  endtask
  task automatic test_write_read();
    logic [7:0] d; bit ok;
    wr(8'h10, 8'hA5);
    rd(8'h10, d, ok);
    checks++; if (!ok || d !== 8'hA5) begin errors++; $display("FAIL write_read: got %h ok=%0d want a5", d, ok); end
    repeat (3) tick();
    checks++; if (miso !== 8'hA5 || vld !== 1'b0) begin errors++; $display("FAIL hold miso: got %h vld=%b want a5 vld=0", miso, vld); end
  endtask
  task automatic test_collision();
    logic [7:0] d; bit ok;
    wr(8'h20, 8'h11);
    addr_wr = 8'h20; mosi = 8'h5A; wr_en = 1; addr_rd = 8'h20; rd_en = 1;
    tick(); wr_en = 0; rd_en = 0;
    repeat (LAT - 1) tick();
    checks++;
    if (vld !== 1'b1 || miso !== (WRF != 0 ? 8'h5A : 8'h11)) begin
      errors++; $display("FAIL collision: got %h vld=%b want %h vld=1", miso, vld, WRF != 0 ? 8'h5A : 8'h11);
    end
    rd(8'h20, d, ok);
    checks++; if (!ok || d !== 8'h5A) begin errors++; $display("FAIL collision followup: got %h ok=%0d want 5a", d, ok); end
  endtask
  task automatic test_back_to_back();
    logic [7:0] hd; logic hv;
    for (int i = 0; i < 4; i++) wr(8'(i), 8'hC0 + 8'(i));
    for (int c = 0; c < 4 + LAT; c++) begin
      rd_en = c < 4; addr_rd = 8'(c);
      tick();
      checks++;
      if (vld !== (c >= LAT - 1 && c < LAT + 3)) begin errors++; $display("FAIL b2b vld c=%0d: got %b", c, vld); end
      else if (vld && miso !== 8'hC0 + 8'(c - (LAT - 1))) begin errors++; $display("FAIL b2b data c=%0d: got %h want %h", c, miso, 8'hC0 + 8'(c - (LAT - 1))); end
      if (c == 1) begin
        hd = miso; hv = vld; en = 0; rd_en = 1; addr_rd = 8'h03;
        repeat (3) tick();
        checks++; if (miso !== hd || vld !== hv) begin errors++; $display("FAIL b2b freeze: got %h/%b want %h/%b", miso, vld, hd, hv); end
        en = 1;
      end
    end
    rd_en = 0;
  endtask
  task automatic test_out_of_range();
    logic [7:0] d; bit ok;
    wr(8'hC7, 8'h3C);
    wr(8'hC8, 8'hFF);
    rd(8'hC8, d, ok);
    checks++; if (!ok || d !== 8'h00) begin errors++; $display("FAIL oor read c8: got %h ok=%0d want 00", d, ok); end
    rd(8'hC7, d, ok);
    checks++; if (!ok || d !== 8'h3C) begin errors++; $display("FAIL last word c7: got %h ok=%0d want 3c", d, ok); end
    rd(8'hFF, d, ok);
    checks++; if (!ok || d !== 8'h00) begin errors++; $display("FAIL oor read ff: got %h ok=%0d want 00", d, ok); end
  endtask
  task automatic test_reset_mid();
    logic [7:0] d; bit ok;
    int seen = 0;
    addr_rd = 8'h10; rd_en = 1; tick(); rd_en = 0;
    rst = 1; tick(); rst = 0;
    checks++; if (vld !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL inflight flush: got vld=%b busy=%b want 0/1", vld, busy); end
    repeat (100) begin
      tick();
      if (vld) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL inflight lost: got %0d pulses want 0", seen); end
    rst = 1; en = 0; tick(); en = 1; rst = 0;
    count_init("reinit");
    rd(8'h10, d, ok);
    checks++; if (!ok || d !== fill(8'h10)) begin errors++; $display("FAIL reinit 10: got %h ok=%0d want %h", d, ok, fill(8'h10)); end
  endtask
  initial begin
    rst = 1; en = 1; wr_en = 0; rd_en = 0; addr_wr = 0; addr_rd = 0; mosi = 0;
    test_reset();
    test_write_read();
    test_collision();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
